// File: rtl/bg_scroll_renderer_if.sv
// ROM bus between the background renderer (master) and the image ROM (slave).
// The renderer drives a registered address; the ROM returns the colour index
// a fixed number of cycles later.
interface bg_scroll_renderer_if #(
  parameter int ADDR_W   = 15,
  parameter int PAL_BITS = 3
);
  logic [ADDR_W-1:0]   rom_addr;
  logic [PAL_BITS-1:0] rom_q;

  modport master (output rom_addr, input rom_q);
  modport slave  (input rom_addr, output rom_q);
endinterface

// File: rtl/bg_scroll_renderer.sv
// Background renderer: maps the beam position to an indexed-colour image in
// an external synchronous ROM, with power-of-2 upscaling, per-frame X/Y
// scrolling with wrap-around and a runtime-writable palette.
// Optional feature macro: BG_FADE_EN adds a brightness stage driven by
// fade_level (one extra cycle of latency).
module bg_scroll_renderer #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int PAL_BITS    = 3,
  parameter int ROM_LAT     = 1,
  parameter int ADDR_W      = 15,
  parameter int SCR_W       = 640,
  parameter int SCR_H       = 480
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    blank,
  bg_scroll_renderer_if.master    rom,
  input  logic                    scroll_en,
  input  logic signed [7:0]       scroll_dx,
  input  logic signed [7:0]       scroll_dy,
  input  logic                    scroll_set,
  input  logic [9:0]              x_set,
  input  logic [9:0]              y_set,
  input  logic                    pal_we,
  input  logic [PAL_BITS-1:0]     pal_waddr,
  input  logic [11:0]             pal_wdata,
  input  logic [3:0]              fade_level,
  output logic                    frame_tick,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue
);

  localparam int                 PAL_N    = 2 ** PAL_BITS;
  localparam logic [10:0]        IMG_W_11 = 11'(IMG_W);
  localparam logic [10:0]        IMG_H_11 = 11'(IMG_H);
  localparam logic signed [11:0] IMG_W_S  = 12'(IMG_W);
  localparam logic signed [11:0] IMG_H_S  = 12'(IMG_H);
  localparam logic [ADDR_W-1:0]  IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [9:0]         SCR_H_10 = 10'(SCR_H);

  // Offsets are always < IMG_W / IMG_H, so one conditional add or subtract
  // is enough to wrap a step whose magnitude is below the image size.
  function automatic logic [9:0] wrap_off(input logic signed [11:0] s,
                                          input logic signed [11:0] m);
    if (s < 0)
      return 10'(s + m);
    else if (s >= m)
      return 10'(s - m);
    else
      return 10'(s);
  endfunction

  logic [9:0]  x_off, y_off;
  logic [10:0] sx_sum, sy_sum, sx, sy;

  // Source coordinate: downscaled beam position plus offset, wrapped once.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    sx_sum = {1'b0, DrawX >> SCALE_SHIFT} + {1'b0, x_off};
    sy_sum = {1'b0, DrawY >> SCALE_SHIFT} + {1'b0, y_off};
    sx     = (sx_sum >= IMG_W_11) ? sx_sum - IMG_W_11 : sx_sum;
    sy     = (sy_sum >= IMG_H_11) ? sy_sum - IMG_H_11 : sy_sum;
  end

  // Address stage: linear ROM address, multiply by the constant width only.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n)
      rom.rom_addr <= '0;
    else
      rom.rom_addr <= ADDR_W'(sy) * IMG_W_A + ADDR_W'(sx);
  end

  logic                    at_bnd, at_bnd_q, tick;
  logic signed [11:0]      x_sum, y_sum;

  assign at_bnd = (DrawX == 10'd0) && (DrawY == SCR_H_10);
  // Only the first boundary cycle counts, even if the beam lingers there.
  assign tick   = at_bnd && !at_bnd_q;
  assign x_sum  = $signed({2'b00, x_off}) + 12'(scroll_dx);
  assign y_sum  = $signed({2'b00, y_off}) + 12'(scroll_dy);

  // Frame boundary: load or step the offsets once per frame and pulse frame_tick.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      at_bnd_q   <= 1'b0;
      frame_tick <= 1'b0;
      x_off      <= '0;
      y_off      <= '0;
    end else begin
      at_bnd_q   <= at_bnd;
      frame_tick <= tick;
      if (tick) begin
        if (scroll_set) begin
          x_off <= x_set;
          y_off <= y_set;
        end else if (scroll_en) begin
          x_off <= wrap_off(x_sum, IMG_W_S);
          y_off <= wrap_off(y_sum, IMG_H_S);
        end
      end
    end
  end

  logic [11:0] palette [PAL_N];
  logic [11:0] pal_rd;

  // Palette RAM: writes land on the edge; a same-cycle lookup sees the old entry.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    // NOTE: the palette is small and must read black after reset, so it is reset explicitly.
    if (!reset_n) begin
      for (int i = 0; i < PAL_N; i++)
        palette[i] <= '0;
    end else if (pal_we) begin
      palette[pal_waddr] <= pal_wdata;
    end
  end

  assign pal_rd = palette[rom.rom_q];

  logic [ROM_LAT:0] blank_pipe;

  // blank travels alongside the address and ROM stages.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)
      blank_pipe <= '0;
    else
      blank_pipe <= {blank_pipe[ROM_LAT-1:0], blank};
  end

  logic [3:0] col_r, col_g, col_b;

  // Colour stage: palette lookup, forced black outside active video.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      col_r <= '0;
      col_g <= '0;
      col_b <= '0;
    end else if (blank_pipe[ROM_LAT]) begin
      col_r <= pal_rd[11:8];
      col_g <= pal_rd[7:4];
      col_b <= pal_rd[3:0];
    end else begin
      col_r <= '0;
      col_g <= '0;
      col_b <= '0;
    end
  end

`ifdef BG_FADE_EN
  logic [3:0] fade_pipe [ROM_LAT+2];

  function automatic logic [3:0] fade_ch(input logic [3:0] c, input logic [3:0] f);
    return 4'(({4'b0, c} * {4'b0, f}) >> 4);
  endfunction

  // fade_level is carried with its pixel so it applies to the matching colour.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= ROM_LAT + 1; i++)
        fade_pipe[i] <= '0;
    end else begin
      fade_pipe[0] <= fade_level;
      for (int i = 1; i <= ROM_LAT + 1; i++)
        fade_pipe[i] <= fade_pipe[i-1];
    end
  end

  // Fade stage: scale each channel by fade_level/16.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= fade_ch(col_r, fade_pipe[ROM_LAT+1]);
      green <= fade_ch(col_g, fade_pipe[ROM_LAT+1]);
      blue  <= fade_ch(col_b, fade_pipe[ROM_LAT+1]);
    end
  end
`else
  logic unused_fade;
  assign unused_fade = ^fade_level;
  assign red   = col_r;
  assign green = col_g;
  assign blue  = col_b;
`endif

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// Self-checking bench for bg_scroll_renderer: directed vector table, hand
// sequences for latency / boundary / reset corners, and randomized pixels
// checked against a coordinate-level model of the image, offsets and palette.
module tb_bg_scroll_renderer;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int SS    = 2;
  localparam int PB    = 3;
  localparam int LAT   = 2;
  localparam int AW    = 15;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
`ifdef BG_FADE_EN
  localparam int FD    = 1;
`else
  localparam int FD    = 0;
`endif
  localparam int PIPE  = LAT + 2 + FD;
  localparam int NPIX  = IMG_W * IMG_H;

  logic              vga_clk = 1'b0;
  logic              reset_n;
  logic [9:0]        draw_x, draw_y;
  logic              blank;
  logic              scroll_en, scroll_set;
  logic signed [7:0] scroll_dx, scroll_dy;
  logic [9:0]        x_set, y_set;
  logic              pal_we;
  logic [PB-1:0]     pal_waddr;
  logic [11:0]       pal_wdata;
  logic [3:0]        fade;
  logic              frame_tick;
  logic [3:0]        red, green, blue;
  logic [11:0]       rgb;

  bg_scroll_renderer_if #(.ADDR_W(AW), .PAL_BITS(PB)) rif ();

  bg_scroll_renderer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_SHIFT(SS), .PAL_BITS(PB),
    .ROM_LAT(LAT), .ADDR_W(AW), .SCR_W(SCR_W), .SCR_H(SCR_H)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
    .blank(blank), .rom(rif), .scroll_en(scroll_en), .scroll_dx(scroll_dx),
    .scroll_dy(scroll_dy), .scroll_set(scroll_set), .x_set(x_set), .y_set(y_set),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .fade_level(fade), .frame_tick(frame_tick), .red(red), .green(green), .blue(blue)
  );

  always #5 vga_clk = ~vga_clk;
  assign rgb = {red, green, blue};

  // Image ROM model with LAT cycles of read latency.
  logic [PB-1:0] rom_mem [NPIX];
  logic [PB-1:0] q_pipe  [LAT];
  always @(posedge vga_clk) begin
    q_pipe[0] <= (int'(rif.rom_addr) < NPIX) ? rom_mem[rif.rom_addr] : '0;
    for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign rif.rom_q = q_pipe[LAT-1];

  // Reference state: offsets and palette as the specification defines them.
  int          m_xoff, m_yoff;
  logic [11:0] m_pal [1<<PB];
  int          n_cmp = 0, n_err = 0;

  typedef struct {
    int xo, yo, dx, dy, addr;
  } vec_t;
  vec_t tbl [9];

  logic [11:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_rom(input bit patterned);
    for (int a = 0; a < NPIX; a++)
      rom_mem[a] = patterned ? PB'((a ^ (a >> 3) ^ (a >> 7)) + a / IMG_W) : PB'(5);
  endtask

  function automatic logic [11:0] col(input logic [11:0] c, input int f);
`ifdef BG_FADE_EN
    int r, g, b;
    r = (int'(c[11:8]) * f) >> 4;
    g = (int'(c[7:4])  * f) >> 4;
    b = (int'(c[3:0])  * f) >> 4;
    return {4'(r), 4'(g), 4'(b)};
`else
    return (f >= 0) ? c : c;
`endif
  endfunction

  function automatic int exp_addr(input int dx, input int dy);
    int sx, sy;
    sx = ((dx >> SS) + m_xoff) % IMG_W;
    sy = ((dy >> SS) + m_yoff) % IMG_H;
    return sy * IMG_W + sx;
  endfunction

  function automatic logic [11:0] exp_rgb(input int dx, input int dy, input logic bl, input int f);
    if (!bl) return 12'h000;
    return col(m_pal[rom_mem[exp_addr(dx, dy)]], f);
  endfunction

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic drive(input int dx, input int dy, input logic bl);
    draw_x = 10'(dx);
    draw_y = 10'(dy);
    blank  = bl;
  endtask

  task automatic pal_write(input int a, input logic [11:0] d);
    pal_we = 1'b1; pal_waddr = PB'(a); pal_wdata = d;
    step();
    pal_we = 1'b0;
    m_pal[a] = d;
  endtask

  function automatic int wrap(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  // One frame boundary cycle followed by one ordinary cycle.
  task automatic boundary(input bit set, input int xs, input int ys,
                          input bit en, input int dx, input int dy);
    scroll_set = set; x_set = 10'(xs); y_set = 10'(ys);
    scroll_en  = en;  scroll_dx = 8'(dx); scroll_dy = 8'(dy);
    drive(0, SCR_H, 1'b0);
    step();
    check("tick_at_boundary", frame_tick, 1);
    if (set) begin
      m_xoff = xs; m_yoff = ys;
    end else if (en) begin
      m_xoff = wrap(m_xoff + dx, IMG_W);
      m_yoff = wrap(m_yoff + dy, IMG_H);
    end
    scroll_set = 1'b0; scroll_en = 1'b0;
    drive(1, SCR_H, 1'b0);
    step();
    check("tick_after_boundary", frame_tick, 0);
  endtask

  task automatic check_origin(input string name, input int exp);
    drive(0, 0, 1'b0);
    step();
    check(name, rif.rom_addr, exp);
  endtask

  task automatic settle(input int dx, input int dy, input logic bl);
    drive(dx, dy, bl);
    for (int i = 0; i <= PIPE; i++) step();
  endtask

  initial begin
    tbl[0] = '{0,   0,   7,   9,   321};
    tbl[1] = '{0,   0,   639, 479, 19199};
    tbl[2] = '{0,   0,   0,   0,   0};
    tbl[3] = '{0,   0,   4,   4,   161};
    tbl[4] = '{150, 100, 39,  0,   16159};
    tbl[5] = '{150, 100, 40,  0,   16000};
    tbl[6] = '{150, 100, 0,   79,  19190};
    tbl[7] = '{150, 100, 0,   80,  150};
    tbl[8] = '{150, 100, 639, 479, 15989};

    reset_n = 1'b0;
    drive(100, 50, 1'b0);
    scroll_en = 0; scroll_set = 0; scroll_dx = 0; scroll_dy = 0;
    x_set = 0; y_set = 0; pal_we = 0; pal_waddr = 0; pal_wdata = 0; fade = 4'd15;
    m_xoff = 0; m_yoff = 0;
    for (int i = 0; i < (1 << PB); i++) m_pal[i] = 12'h000;
    fill_rom(1'b1);

    // Reset state, then black output with an all-zero palette.
    step(); step(); step();
    check("rst_rgb", rgb, 0);
    check("rst_addr", rif.rom_addr, 0);
    check("rst_tick", frame_tick, 0);
    #2 reset_n = 1'b1;
    drive(200, 300, 1'b1);
    for (int i = 0; i < PIPE + 2; i++) begin
      step();
      check("black_after_reset", rgb, 0);
    end

    // Blank rise/fall latency with constant index 5.
    pal_write(5, 12'hF80);
    fill_rom(1'b0);
    settle(4, 4, 1'b0);
    drive(4, 4, 1'b1);
    for (int n = 1; n <= PIPE + 1; n++) begin
      step();
      check("blank_rise", rgb, (n >= PIPE) ? col(12'hF80, 15) : 12'h000);
    end
    drive(4, 4, 1'b0);
    for (int n = 1; n <= PIPE + 1; n++) begin
      step();
      check("blank_fall", rgb, (n >= PIPE) ? 12'h000 : col(12'hF80, 15));
    end

    // Lookup in the same cycle as a write to that entry returns the old colour.
    settle(4, 4, 1'b1);
    pal_we = 1'b1; pal_waddr = PB'(5); pal_wdata = 12'h0F0;
    step();
    pal_we = 1'b0;
    m_pal[5] = 12'h0F0;
    for (int n = 0; n <= FD + 1; n++) begin
      if (n > 0) step();
      check("pal_old_then_new", rgb, (n <= FD) ? col(12'hF80, 15) : col(12'h0F0, 15));
    end

    // Address stage vectors.
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].xo != m_xoff || tbl[i].yo != m_yoff)
        boundary(1'b1, tbl[i].xo, tbl[i].yo, 1'b0, 0, 0);
      drive(tbl[i].dx, tbl[i].dy, 1'b0);
      step();
      check($sformatf("addr_vec%0d", i), rif.rom_addr, tbl[i].addr);
    end

    // Scrolling with wrap in both directions.
    boundary(1'b1, 150, 0, 1'b0, 0, 0);
    check_origin("xoff_150", 150);
    boundary(1'b0, 0, 0, 1'b1, 20, 0);
    check_origin("xoff_wrap_pos", 10);
    boundary(1'b0, 0, 0, 1'b1, -30, 0);
    check_origin("xoff_wrap_neg", 140);
    boundary(1'b0, 0, 0, 1'b1, 0, -5);
    check_origin("yoff_wrap_neg", 115 * IMG_W + 140);
    boundary(1'b1, 3, 7, 1'b1, 5, 9);
    check_origin("set_priority", 7 * IMG_W + 3);

    // scroll_en mid-frame is ignored.
    scroll_en = 1'b1; scroll_dx = 8'sd50; scroll_dy = 8'sd50;
    drive(100, 50, 1'b1); step();
    drive(0, 200, 1'b1); step();
    scroll_en = 1'b0;
    boundary(1'b0, 0, 0, 1'b0, 0, 0);
    check_origin("midframe_en_ignored", 7 * IMG_W + 3);

    // Beam parked on the boundary: only the first cycle updates.
    scroll_en = 1'b1; scroll_dx = 8'sd1; scroll_dy = 8'sd0;
    drive(0, SCR_H, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step();
      check("parked_tick", frame_tick, (n == 0) ? 1 : 0);
    end
    scroll_en = 1'b0;
    m_xoff = wrap(m_xoff + 1, IMG_W);
    check_origin("parked_single_step", 7 * IMG_W + 4);

    // Randomized frames against the model.
    fill_rom(1'b1);
    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < (1 << PB); a++) pal_write(a, 12'($urandom));
      if (f == 0)
        boundary(1'b1, $urandom_range(0, IMG_W - 1), $urandom_range(0, IMG_H - 1), 1'b0, 0, 0);
      else
        boundary(1'b0, 0, 0, 1'b1, $urandom_range(0, 254) - 127, $urandom_range(0, 238) - 119);
      exp_q.delete();
      for (int i = 0; i < 250 + PIPE; i++) begin
        int dx, dy, fl;
        logic bl;
        dx = $urandom_range(0, SCR_W - 1);
        dy = $urandom_range(0, SCR_H - 1);
        bl = 1'($urandom_range(0, 1));
        fl = $urandom_range(0, 15);
        scroll_en = 1'($urandom_range(0, 1)); scroll_dx = 8'($urandom);
        fade = 4'(fl);
        drive(dx, dy, bl);
        exp_q.push_back(exp_rgb(dx, dy, bl, fl));
        step();
        check("rand_addr", rif.rom_addr, exp_addr(dx, dy));
        if (exp_q.size() >= PIPE) check("rand_rgb", rgb, exp_q.pop_front());
      end
      scroll_en = 1'b0; fade = 4'd15;
    end

`ifdef BG_FADE_EN
    // Fade levels on a white pixel.
    fill_rom(1'b0);
    pal_write(5, 12'hFFF);
    fade = 4'd8;
    settle(4, 4, 1'b1);
    check("fade_8", rgb, 12'h777);
    fade = 4'd0;
    settle(4, 4, 1'b1);
    check("fade_0", rgb, 12'h000);
    fade = 4'd15;
`endif

    // Reset asserted mid-line while outputs are active and frame_tick is high.
    fill_rom(1'b0);
    pal_write(5, 12'hF80);
    settle(4, 4, 1'b1);
    check("pre_reset_rgb", rgb, col(12'hF80, 15));
    drive(0, SCR_H, 1'b1);
    step();
    check("pre_reset_tick", frame_tick, 1);
    check("pre_reset_addr", rif.rom_addr, exp_addr(0, SCR_H));
    #2 reset_n = 1'b0;
    #1;
    check("midline_rst_rgb", rgb, 0);
    check("midline_rst_addr", rif.rom_addr, 0);
    check("midline_rst_tick", frame_tick, 0);
    drive(4, 4, 1'b1);
    step(); step();
    #2 reset_n = 1'b1;
    m_xoff = 0; m_yoff = 0;
    for (int i = 0; i < (1 << PB); i++) m_pal[i] = 12'h000;
    for (int i = 0; i <= PIPE; i++) step();
    check("post_reset_rgb", rgb, 0);
    check("post_reset_addr", rif.rom_addr, 161);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
